// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and a helper for sizing the digit count.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Smallest digit count that can never overflow for a w-bit operand.
    // Signed operands peak at a magnitude of 2^(w-1); unsigned at 2^w - 1.
    function automatic int min_digits(input int w, input bit is_signed);
        longint unsigned maxv;
        longint unsigned p;
        int              d;
        if (is_signed) begin
            maxv = longint'(1) << (w - 1);
        end else begin
            maxv = (longint'(1) << w) - 1;
        end
        p = 10;
        d = 1;
        while (p <= maxv) begin
            p = p * 10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Handshake bundle between a binary producer (master) and the converter (slave).
interface bin2bcd_if
    import bin2bcd_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     bin;
    logic             out_valid;
    logic             out_ready;
    logic [4*D-1:0]   bcd;
    logic             sign;
    logic             ovf;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, sign, ovf
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, sign, ovf
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one adjust+shift step per clock,
// W steps per conversion, with valid/ready on both sides.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int D      = 5,
    parameter int SIGNED = 0
) (
    input  logic    clk,
    input  logic    rst,
    bin2bcd_if.slave io
);
    localparam int CNT_W = $clog2(W + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [4*D-1:0]     acc_q, acc_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [4*D-1:0]     bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [4*D-1:0]     acc_adj;
    logic [4*D-1:0]     acc_shift;
    logic               neg;
    logic [W-1:0]       mag;

    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (acc_adj[4*g +: 4])
        );
    end

    if (SIGNED != 0) begin : g_signed
        assign neg = io.bin[W-1];
    end else begin : g_unsigned
        assign neg = 1'b0;
    end

    // W-bit negate: the most negative operand wraps to 2^(W-1) as intended.
    assign mag       = neg ? (~io.bin + W'(1)) : io.bin;
    assign acc_shift = {acc_adj[4*D-2:0], shreg_q[W-1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    shreg_d   = mag;
                    sign_d    = neg;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    ovf_d     = 1'b0;
                    cnt_d     = CNT_W'(W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                acc_d     = acc_shift;
                shreg_d   = {shreg_q[W-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | acc_adj[4*D-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Publish only the finished value; intermediate steps stay hidden.
                    bcd_d       = acc_shift;
                    ovf_d       = ovf_acc_q | acc_adj[4*D-1];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE) && !rst;
    assign io.out_valid = out_valid_q;
    assign io.bcd       = bcd_q;
    assign io.sign      = sign_q;
    assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq in three configurations
// against a decimal reference model built from division by ten.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int DA = min_digits(16, 1'b0);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_in_valid;
    logic        tb_out_ready;
    logic [31:0] tb_bin;
    int          sel;
    int          cyc = 0;
    int          checks;
    int          errors;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_if #(.W(16), .D(DA)) ia ();
    bin2bcd_if #(.W(8),  .D(2))  ib ();
    bin2bcd_if #(.W(8),  .D(3))  ic ();

    bin2bcd_seq #(.W(16), .D(DA), .SIGNED(0)) dut_a (.clk(clk), .rst(rst), .io(ia.slave));
    bin2bcd_seq #(.W(8),  .D(2),  .SIGNED(0)) dut_b (.clk(clk), .rst(rst), .io(ib.slave));
    bin2bcd_seq #(.W(8),  .D(3),  .SIGNED(1)) dut_c (.clk(clk), .rst(rst), .io(ic.slave));

    assign ia.in_valid  = tb_in_valid && (sel == 0);
    assign ib.in_valid  = tb_in_valid && (sel == 1);
    assign ic.in_valid  = tb_in_valid && (sel == 2);
    assign ia.out_ready = tb_out_ready && (sel == 0);
    assign ib.out_ready = tb_out_ready && (sel == 1);
    assign ic.out_ready = tb_out_ready && (sel == 2);
    assign ia.bin       = tb_bin[15:0];
    assign ib.bin       = tb_bin[7:0];
    assign ic.bin       = tb_bin[7:0];

    logic        obs_in_ready, obs_out_valid, obs_sign, obs_ovf;
    logic [39:0] obs_bcd;

    always_comb begin
        obs_in_ready  = ia.in_ready;
        obs_out_valid = ia.out_valid;
        obs_sign      = ia.sign;
        obs_ovf       = ia.ovf;
        obs_bcd       = {20'b0, ia.bcd};
        if (sel == 1) begin
            obs_in_ready  = ib.in_ready;
            obs_out_valid = ib.out_valid;
            obs_sign      = ib.sign;
            obs_ovf       = ib.ovf;
            obs_bcd       = {32'b0, ib.bcd};
        end else if (sel == 2) begin
            obs_in_ready  = ic.in_ready;
            obs_out_valid = ic.out_valid;
            obs_sign      = ic.sign;
            obs_ovf       = ic.ovf;
            obs_bcd       = {28'b0, ic.bcd};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: take the magnitude arithmetically, then peel decimal digits.
    function automatic void model(input longint unsigned v, input int w, input int d,
                                  input bit sg, output logic [39:0] eb,
                                  output logic es, output logic eo);
        longint unsigned m;
        es = sg && v[w-1];
        m  = es ? ((longint'(1) << w) - v) : v;
        eb = '0;
        for (int i = 0; i < d; i++) begin
            eb[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        eo = (m != 0);
    endfunction

    function automatic int cfg_w(input int s);
        return (s == 0) ? 16 : 8;
    endfunction

    function automatic int cfg_d(input int s);
        return (s == 0) ? DA : ((s == 1) ? 2 : 3);
    endfunction

    int last_acc;

    task automatic wait_ready();
        int n = 0;
        while (!obs_in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!obs_out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic convert(input int s, input logic [31:0] v, input bit hold, input string tag);
        longint unsigned vm;
        logic [39:0]     eb;
        logic            es, eo;
        int              n;
        sel = s;
        vm  = longint'(v) & ((longint'(1) << cfg_w(s)) - 1);
        model(vm, cfg_w(s), cfg_d(s), s == 2, eb, es, eo);
        wait_ready();
        tb_bin      = v;
        tb_in_valid = 1'b1;
        @(posedge clk); #1;
        last_acc    = cyc;
        tb_in_valid = 1'b0;
        tb_bin      = $urandom;
        chk({tag, "_busy"}, obs_in_ready, 1'b0);
        wait_valid(n);
        chk({tag, "_lat"}, n, cfg_w(s));
        chk({tag, "_bcd"}, obs_bcd, eb);
        chk({tag, "_sign"}, obs_sign, es);
        chk({tag, "_ovf"}, obs_ovf, eo);
        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) tb_out_ready = 1'b0;
        chk({tag, "_drop"}, obs_out_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] v1, v2;
        logic [39:0] eb;
        logic        es, eo;
        int          n, prev, seen;

        checks = 0; errors = 0;
        tb_in_valid = 1'b0; tb_out_ready = 1'b0; tb_bin = '0; sel = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_in_ready", obs_in_ready, 1'b0);
            chk("rst_out_valid", obs_out_valid, 1'b0);
            chk("rst_bcd", obs_bcd, '0);
            chk("rst_sign", obs_sign, 1'b0);
            chk("rst_ovf", obs_ovf, 1'b0);
        end
        rst = 1'b0; #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("post_rst_ready", obs_in_ready, 1'b1);
        end

        convert(0, 32'hFFFF, 1'b0, "a_max");
        convert(0, 32'h0, 1'b0, "a_zero");
        convert(1, 32'd255, 1'b0, "b_255");
        convert(1, 32'd99, 1'b0, "b_99");
        convert(2, 32'h80, 1'b0, "c_80");
        convert(2, 32'hFF, 1'b0, "c_ff");
        convert(2, 32'h7F, 1'b0, "c_7f");

        // Backpressure with in_valid held and bin toggling throughout.
        sel = 0;
        v1  = 16'($urandom);
        model(longint'(v1), 16, DA, 1'b0, eb, es, eo);
        wait_ready();
        tb_bin = {16'b0, v1}; tb_in_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!obs_out_valid && n < 200) begin
            tb_bin = $urandom;
            @(posedge clk); #1; n++;
        end
        chk("bp_lat", n, 16);
        for (int i = 0; i < 5; i++) begin
            tb_bin = $urandom;
            @(posedge clk); #1;
            chk("bp_in_ready", obs_in_ready, 1'b0);
            chk("bp_valid", obs_out_valid, 1'b1);
            chk("bp_bcd", obs_bcd, eb);
            chk("bp_ovf", obs_ovf, eo);
            chk("bp_sign", obs_sign, es);
        end
        v2 = 16'($urandom);
        tb_bin = {16'b0, v2};
        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        tb_out_ready = 1'b0;
        chk("bp_release_valid", obs_out_valid, 1'b0);
        chk("bp_release_ready", obs_in_ready, 1'b1);
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        chk("bp_next_accept", obs_in_ready, 1'b0);
        model(longint'(v2), 16, DA, 1'b0, eb, es, eo);
        wait_valid(n);
        chk("bp_next_lat", n, 16);
        chk("bp_next_bcd", obs_bcd, eb);
        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        tb_out_ready = 1'b0;

        // Reset five cycles into a conversion.
        sel = 0;
        wait_ready();
        tb_bin = 32'h4321; tb_in_valid = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready", obs_in_ready, 1'b0);
        chk("mid_rst_valid", obs_out_valid, 1'b0);
        chk("mid_rst_bcd", obs_bcd, '0);
        rst = 1'b0; #1;
        chk("mid_rst_release", obs_in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (obs_out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 0);
        convert(0, 32'd1234, 1'b0, "a_1234");

        // Back-to-back random traffic with out_ready tied high.
        tb_out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 1000; i++) begin
            convert(0, $urandom, 1'b1, "rnd");
            if (prev >= 0) chk("rnd_spacing", last_acc - prev, 18);
            prev = last_acc;
        end
        tb_out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
